// File: rtl/cr_ram1_sched.sv
// cr_ram1_sched: credit-gated round-robin scheduler for the RAM1 read engine.
// One requester is picked at a time and its burst is written to the command FIFO
// as {4'h0, len[3:0], addr[7:0]}. A word-credit counter bounds the words in flight
// to the downstream buffer size.
//
// Handshake semantics (all interfaces):
//   - Requester i raises req[i] with req_addr/req_len slices stable and holds them
//     until it sees the one-cycle req_ack[i] pulse; the cycle req_ack[i] is high the
//     request is treated as consumed, so req[i] may stay high only to post a new burst.
//   - fifo_wr is a one-cycle write strobe qualified by fifo_full=0 on the same edge;
//     fifo_data is valid in the cycle fifo_wr=1.
//   - credit_ret is a one-cycle pulse returning exactly one word of credit.

module cr_ram1_sched #(
    parameter int N_REQ   = 4,
    parameter int CREDITS = 32
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_addr,
    input  logic [4*N_REQ-1:0]   req_len,
    output logic [N_REQ-1:0]     req_ack,
    output logic [15:0]          fifo_data,
    output logic                 fifo_wr,
    input  logic                 fifo_full,
    input  logic                 credit_ret,
    output logic [7:0]           credit_cnt,
    output logic                 busy,
    output logic                 credit_err,
    output logic [0:0]           state_dbg
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [7:0] CRED_MAX = 8'(CREDITS);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [0:0]       state_q,     state_d;
    logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]   id_q,        id_d;
    logic [7:0]       addr_q,      addr_d;
    logic [3:0]       len_q,       len_d;
    logic [7:0]       credit_q,    credit_d;
    logic             err_q,       err_d;
    logic             fifo_wr_q,   fifo_wr_d;
    logic [15:0]      fifo_data_q, fifo_data_d;
    logic [N_REQ-1:0] req_ack_q,   req_ack_d;
    logic             busy_q,      busy_d;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] eligible;
    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [7:0]       win_addr;
    logic [3:0]       win_len_raw;
    logic [3:0]       win_len;
    logic             issue;
    logic [IDW-1:0]   next_ptr;

    // Cyclic search for the first eligible requester at or after rr_ptr.
    // A requester acked last edge is masked: its req/fields are still stale.
    always_comb begin
        int j;
        j           = 0;
        eligible    = req & ~req_ack_q;
        win_found   = 1'b0;
        win_id      = '0;
        win_addr    = '0;
        win_len_raw = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(rr_ptr_q) + k) % N_REQ;
            if (!win_found && eligible[j]) begin
                win_found   = 1'b1;
                win_id      = IDW'(j);
                win_addr    = req_addr[8*j +: 8];
                win_len_raw = req_len[4*j +: 4];
            end
        end
    end

    // The engine has no zero-length burst, so len=0 is issued (and charged) as 1.
    assign win_len = (win_len_raw == 4'd0) ? 4'd1 : win_len_raw;

    // Issue needs FIFO room and enough credits, using the pre-edge credit count.
    assign issue = (state_q == S_WAIT) && !fifo_full && (credit_q >= {4'b0000, len_q});

    // Round-robin pointer advances to the slot after the requester just served.
    assign next_ptr = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);

    // FSM next-state and registered output decode.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        busy_d      = busy_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        req_ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    id_d    = win_id;
                    addr_d  = win_addr;
                    len_d   = win_len;
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                // While blocked the latched winner is held; nobody bypasses it.
                if (issue) begin
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = {4'h0, len_q, addr_q};
                    for (int k = 0; k < N_REQ; k++) begin
                        req_ack_d[k] = (id_q == IDW'(k));
                    end
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Credit accounting: issue and return may land on the same edge.
    // A lone return at the maximum saturates and flags a sticky error.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (issue) begin
            credit_d = credit_q - {4'b0000, len_q} + {7'b0000000, credit_ret};
        end else if (credit_ret) begin
            if (credit_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + 8'd1;
            end
        end
    end

    // FSM and command datapath registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            req_ack_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
            req_ack_q   <= req_ack_d;
        end
    end

    // Credit counter and sticky overflow flag; reset reloads a full budget.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            credit_q <= CRED_MAX;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign req_ack    = req_ack_q;
    assign fifo_data  = fifo_data_q;
    assign fifo_wr    = fifo_wr_q;
    assign credit_cnt = credit_q;
    assign busy       = busy_q;
    assign credit_err = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_cr_ram1_sched.sv
// tb_cr_ram1_sched: scoreboard bench for the RAM1 command scheduler.
module tb_cr_ram1_sched;

  localparam int N_REQ = 4;
  localparam int W     = 20; // {req_ack[3:0], fifo_data[15:0]}

  logic                clk;
  logic                reset_p;
  logic [N_REQ-1:0]    req;
  logic [8*N_REQ-1:0]  req_addr;
  logic [4*N_REQ-1:0]  req_len;
  logic [N_REQ-1:0]    req_ack;
  logic [15:0]         fifo_data;
  logic                fifo_wr;
  logic                fifo_full;
  logic                credit_ret;
  logic [7:0]          credit_cnt;
  logic                busy;
  logic                credit_err;
  logic [0:0]          state_dbg;

  logic [W-1:0] exp_q[$];

  int n_cmp;
  int n_err;
  int cyc;
  int last_wr;
  bit chk_gap;

  cr_ram1_sched #(.N_REQ(N_REQ), .CREDITS(32)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .req        (req),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_ack    (req_ack),
    .fifo_data  (fifo_data),
    .fifo_wr    (fifo_wr),
    .fifo_full  (fifo_full),
    .credit_ret (credit_ret),
    .credit_cnt (credit_cnt),
    .busy       (busy),
    .credit_err (credit_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (reset_p) begin
      last_wr = -1;
    end else begin
      if (fifo_wr) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_wr", {16'h0, fifo_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("fifo_data", {16'h0, fifo_data}, {16'h0, e[15:0]});
          check_eq("req_ack", {28'h0, req_ack}, {28'h0, e[19:16]});
        end
        if (chk_gap && last_wr >= 0) check_eq("wr_gap", cyc - last_wr, 2);
        last_wr = cyc;
      end else if (req_ack != '0) begin
        check_eq("ack_without_wr", {28'h0, req_ack}, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_p    = 1'b1;
    req        = '0;
    req_addr   = '0;
    req_len    = '0;
    fifo_full  = 1'b0;
    credit_ret = 1'b0;
    chk_gap    = 1'b0;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [3:0] l);
    req_addr[8*i +: 8] = a;
    req_len[4*i +: 4]  = l;
    req[i]             = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [7:0] a, input logic [3:0] l);
    logic [3:0] ack;
    logic [3:0] il;
    ack = 4'(1 << i);
    il  = (l == 4'd0) ? 4'd1 : l;
    exp_q.push_back({ack, 4'h0, il, a});
  endtask

  // Waits for the next fifo_wr; lat counts negedges from the call.
  task automatic wait_wr(output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (fifo_wr) return;
      if (lat >= 60) begin
        check_eq("wr_timeout", lat, 0);
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int wr_seen;
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    last_wr = -1;

    // T1: reset values, single burst, 2-clock latency, credit cost
    do_reset();
    check_eq("rst_credit", credit_cnt, 32);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr", fifo_wr, 0);
    check_eq("rst_ack", req_ack, 0);
    check_eq("rst_data", fifo_data, 0);
    check_eq("rst_err", credit_err, 0);
    set_req(0, 8'h10, 4'd4);
    push_exp(0, 8'h10, 4'd4);
    wait_wr(lat);
    check_eq("t1_latency", lat, 2);
    check_eq("t1_credit", credit_cnt, 28);
    req = req & ~req_ack;
    @(negedge clk);
    check_eq("t1_idle", busy, 0);
    check_eq("t1_sb_empty", exp_q.size(), 0);

    // T2: all requesters held, round-robin order, one write per 2 clocks
    do_reset();
    chk_gap = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_req(i, 8'(8'h20 + i), 4'd1);
    for (int k = 0; k < 8; k++) push_exp(k % N_REQ, 8'(8'h20 + (k % N_REQ)), 4'd1);
    for (int k = 0; k < 8; k++) wait_wr(lat);
    req = '0;
    chk_gap = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t2_credit", credit_cnt, 24);
    check_eq("t2_sb_empty", exp_q.size(), 0);

    // T3: credit exhaustion stalls, 13 returns release the third burst
    do_reset();
    set_req(0, 8'h30, 4'd15);
    for (int k = 0; k < 3; k++) push_exp(0, 8'h30, 4'd15);
    wait_wr(lat);
    wait_wr(lat);
    check_eq("t3_credit_2", credit_cnt, 2);
    wr_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (fifo_wr) wr_seen++;
    end
    check_eq("t3_stall_busy", busy, 1);
    for (int k = 0; k < 13; k++) begin
      credit_ret = 1'b1;
      @(negedge clk);
      if (fifo_wr) wr_seen++;
    end
    credit_ret = 1'b0;
    check_eq("t3_no_wr_stalled", wr_seen, 0);
    check_eq("t3_credit_15", credit_cnt, 15);
    wait_wr(lat);
    check_eq("t3_release_lat", lat, 1);
    check_eq("t3_credit_0", credit_cnt, 0);
    req = '0;
    @(negedge clk);
    check_eq("t3_sb_empty", exp_q.size(), 0);

    // T4: fifo_full blocks issue, fields held, write 1 clk after release
    do_reset();
    fifo_full = 1'b1;
    set_req(1, 8'h44, 4'd2);
    push_exp(1, 8'h44, 4'd2);
    wr_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_wr) wr_seen++;
    end
    check_eq("t4_no_wr_full", wr_seen, 0);
    check_eq("t4_busy", busy, 1);
    fifo_full = 1'b0;
    wait_wr(lat);
    check_eq("t4_lat", lat, 1);
    check_eq("t4_credit", credit_cnt, 30);
    req = req & ~req_ack;
    @(negedge clk);

    // T5: len=0 issued as len=1, address 8'hFF
    do_reset();
    set_req(2, 8'hFF, 4'd0);
    push_exp(2, 8'hFF, 4'd0);
    wait_wr(lat);
    check_eq("t5_credit", credit_cnt, 31);
    req = req & ~req_ack;
    @(negedge clk);

    // T7: issue and credit return on the same edge
    do_reset();
    set_req(0, 8'h60, 4'd4);
    push_exp(0, 8'h60, 4'd4);
    @(negedge clk);
    credit_ret = 1'b1;
    wait_wr(lat);
    credit_ret = 1'b0;
    check_eq("t7_credit", credit_cnt, 29);
    check_eq("t7_no_err", credit_err, 0);
    req = req & ~req_ack;
    @(negedge clk);

    // T6: return at full credit saturates and sets sticky error; async reset mid-wait
    do_reset();
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    check_eq("t6_credit_sat", credit_cnt, 32);
    check_eq("t6_err_set", credit_err, 1);
    fifo_full = 1'b1;
    set_req(3, 8'h05, 4'd3);
    repeat (2) @(negedge clk);
    check_eq("t6_wait_busy", busy, 1);
    check_eq("t6_err_sticky", credit_err, 1);
    #2 reset_p = 1'b1;
    #1;
    check_eq("t6_arst_busy", busy, 0);
    check_eq("t6_arst_credit", credit_cnt, 32);
    check_eq("t6_arst_err", credit_err, 0);
    check_eq("t6_arst_data", fifo_data, 0);
    check_eq("t6_arst_state", state_dbg, 0);
    req = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    reset_p = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_discarded", busy, 0);
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
